parking_lot_main: RTL and testbench
===================================

// Module: parking_lot_main
// PURPOSE
//  Parking-lot occupancy counter driven by two gate light-barrier sensors, A (outer) and B (inner).
//  It decodes the blocking sequence of the two sensors to detect one complete car entry or exit.
//  It keeps a saturating occupancy count. Top-level block: sensors come straight from pins, count drives a display.
// PARAMETERS
//  WIDTH       3  width of count
//  MAX_COUNT   7  saturation ceiling for count (<= 2**WIDTH-1)
//  SYNC_STAGES 2  flip-flop stages in each sensor synchronizer (>=2)
// PORTS
//  clk       in   1      single system clock, all logic on rising edge
//  reset     in   1      synchronous, active-low reset (0 = reset, sampled on rising clk)
//  sensor_a  in   1      outer sensor, active-low: 0 = beam blocked, 1 = clear; asynchronous
//  sensor_b  in   1      inner sensor, active-low: 0 = beam blocked, 1 = clear; asynchronous
//  count     out  WIDTH  cars currently inside, registered
// BEHAVIOUR
//  Reset (reset==0 at rising edge):
//  - all sync flops load 1 (clear); FSM -> IDLE; count -> 0.
//  - Reset dominates any in-progress sequence; a half-finished passage is discarded.
//  Synchronizers: each sensor passes SYNC_STAGES flops; FSM sees synced A,B.
//  Notation AB below is the synced pair, where 1 = clear and 0 = blocked.
//  FSM states and transitions (any AB not listed -> ERR):
//  - IDLE: 11 stay; 01 -> IN1; 10 -> OUT1; 00 -> ERR
//  - IN1: 01 stay; 00 -> IN2; 11 -> IDLE (car backed out)
//  - IN2: 00 stay; 10 -> IN3; 01 -> IN1
//  - IN3: 10 stay; 00 -> IN2; 11 -> IDLE + entry event
//  - OUT1: 10 stay; 00 -> OUT2; 11 -> IDLE
//  - OUT2: 00 stay; 01 -> OUT3; 10 -> OUT1
//  - OUT3: 01 stay; 00 -> OUT2; 11 -> IDLE + exit event
//  - ERR: stay until 11, then -> IDLE; never changes count
//  Count update:
//  - Entry event: count+1, saturating at MAX_COUNT (count==MAX_COUNT stays MAX_COUNT).
//  - Exit event: count-1, saturating at 0 (count==0 stays 0).
//  - Entry and exit events are mutually exclusive by construction; no wrap-around ever.
//  Latency:
//  - count changes on the rising edge where the FSM leaves IN3/OUT3.
//  - That edge is the (SYNC_STAGES+1)th rising edge after the raw inputs return to 11.
//  - Every other output change is impossible; count is held otherwise.
//  Glitch handling:
//  - A change shorter than one clock may be missed.
//  - A missed change may drive the FSM to ERR or IDLE; it must never yield a spurious count.
//  Simultaneous A and B change: handled by the table, e.g. IN1 seeing 10 -> ERR.
// TESTING
//  1 Reset: hold reset=0 2 cycles with A=B=1 -> count==0, FSM IDLE.
//  2 Entry: AB 11->01->00->10->11, each held 4 cycles.
//    -> count 0->1, changing exactly SYNC_STAGES+1 edges after final 11.
//  3 Exit after entry: AB 11->10->00->01->11 -> count 1->0.
//    A further exit sequence at 0 -> count stays 0.
//  4 Saturation: 8 entry sequences -> count 1..7 then stays 7.
//  5 Abort and backtrack, each -> count unchanged:
//    - 11->01->11
//    - 11->01->00->01->11
//    - 11->00->11 via ERR
//    - 11->01->10->11 via ERR
//  6 Reset mid-sequence: count=3, AB 11->01->00, reset=0 one cycle, release, AB->11.
//    -> count==0, no entry counted.

Source files
------------

// File: rtl/parking_lot_main.sv
// Parking-lot occupancy counter.
// Two active-low light barriers (A outer, B inner) are synchronized, and the
// order in which they are blocked is decoded into one entry or one exit
// event. The count saturates at both ends.
module parking_lot_main #(
  parameter int WIDTH       = 3,
  parameter int MAX_COUNT   = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IN1  = 3'd1,
    IN2  = 3'd2,
    IN3  = 3'd3,
    OUT1 = 3'd4,
    OUT2 = 3'd5,
    OUT3 = 3'd6,
    ERR  = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             ab;
  state_t                 state;
  state_t                 state_nxt;
  logic                   entry_ev;
  logic                   exit_ev;

  // Increment that holds at the ceiling instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c);
    if (c >= MAX_C) return MAX_C;
    return c + ONE;
  endfunction

  // Decrement that holds at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] c);
    if (c == '0) return '0;
    return c - ONE;
  endfunction

  // Synchronizer chains; reset loads "clear" so no false blocking is seen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], sensor_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], sensor_b};
    end
  end

  assign ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // FSM state register; reset discards any half-finished passage.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode of the blocking sequence; events fire on leaving IN3/OUT3.
  always_comb begin
    state_nxt = state;
    entry_ev  = 1'b0;
    exit_ev   = 1'b0;
    case (state)
      IDLE: begin
        case (ab)
          2'b11:   state_nxt = IDLE;
          2'b01:   state_nxt = IN1;
          2'b10:   state_nxt = OUT1;
          default: state_nxt = ERR;
        endcase
      end
      IN1: begin
        case (ab)
          2'b01:   state_nxt = IN1;
          2'b00:   state_nxt = IN2;
          2'b11:   state_nxt = IDLE;
          default: state_nxt = ERR;
        endcase
      end
      IN2: begin
        case (ab)
          2'b00:   state_nxt = IN2;
          2'b10:   state_nxt = IN3;
          2'b01:   state_nxt = IN1;
          default: state_nxt = ERR;
        endcase
      end
      IN3: begin
        case (ab)
          2'b10:   state_nxt = IN3;
          2'b00:   state_nxt = IN2;
          2'b11: begin
            state_nxt = IDLE;
            entry_ev  = 1'b1;
          end
          default: state_nxt = ERR;
        endcase
      end
      OUT1: begin
        case (ab)
          2'b10:   state_nxt = OUT1;
          2'b00:   state_nxt = OUT2;
          2'b11:   state_nxt = IDLE;
          default: state_nxt = ERR;
        endcase
      end
      OUT2: begin
        case (ab)
          2'b00:   state_nxt = OUT2;
          2'b01:   state_nxt = OUT3;
          2'b10:   state_nxt = OUT1;
          default: state_nxt = ERR;
        endcase
      end
      OUT3: begin
        case (ab)
          2'b01:   state_nxt = OUT3;
          2'b00:   state_nxt = OUT2;
          2'b11: begin
            state_nxt = IDLE;
            exit_ev   = 1'b1;
          end
          default: state_nxt = ERR;
        endcase
      end
      ERR: begin
        if (ab == 2'b11) state_nxt = IDLE;
        else             state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy register, updated on the same edge the FSM leaves IN3/OUT3.
  always_ff @(posedge clk) begin
    if (!reset)        count <= '0;
    else if (entry_ev) count <= sat_inc(count);
    else if (exit_ev)  count <= sat_dec(count);
  end

endmodule

// File: tb/tb_parking_lot_main.sv
// Bench for parking_lot_main: directed sensor sequences, expected count
// changes queued by the stimulus and matched by an independent monitor.
module tb_parking_lot_main;

  localparam int WIDTH       = 3;
  localparam int MAX_COUNT   = 7;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sensor_a = 1'b1;
  logic             sensor_b = 1'b1;
  logic [WIDTH-1:0] count;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   model    = 0;
  bit   mon_en   = 1'b0;
  logic [WIDTH-1:0] prev_count;

  parking_lot_main #(
    .WIDTH(WIDTH),
    .MAX_COUNT(MAX_COUNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every change of count must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && (count !== prev_count)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change: count %0d -> %0d at cycle %0d, expected no change",
                 prev_count, count, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("change_value", int'(count), e.val);
        check("change_cycle", cyc, e.cyc);
      end
    end
    prev_count = count;
  end

  // Drive the raw sensor pair just after an edge and hold it for n edges.
  task automatic drive(input logic [1:0] abv, input int n);
    sensor_a = abv[1];
    sensor_b = abv[0];
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic entry_seq();
    drive(2'b01, 4);
    drive(2'b00, 4);
    drive(2'b10, 4);
    if (model < MAX_COUNT) begin
      model++;
      exp_q.push_back('{model, cyc + LAT});
    end
    drive(2'b11, 6);
    check("after_entry", int'(count), model);
  endtask

  task automatic exit_seq();
    drive(2'b10, 4);
    drive(2'b00, 4);
    drive(2'b01, 4);
    if (model > 0) begin
      model--;
      exp_q.push_back('{model, cyc + LAT});
    end
    drive(2'b11, 6);
    check("after_exit", int'(count), model);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    if (model != 0) exp_q.push_back('{0, cyc + 1});
    model = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset with both beams clear
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(2'b11, 2);
    check("reset_count", int'(count), 0);
    prev_count = count;
    mon_en = 1'b1;
    reset = 1'b1;
    drive(2'b11, 3);
    check("idle_after_reset", int'(count), 0);

    // Entry, then exit, then exit at zero
    entry_seq();
    exit_seq();
    exit_seq();
    check("exit_at_zero", int'(count), 0);

    // Saturation: eight entries
    for (int i = 0; i < 8; i++) entry_seq();
    check("saturated", int'(count), MAX_COUNT);

    // Bring back to a mid value for abort tests
    exit_seq();
    exit_seq();

    // Aborts and backtracks leave the count alone
    drive(2'b01, 4); drive(2'b11, 6);
    check("abort_backout", int'(count), model);
    drive(2'b01, 4); drive(2'b00, 4); drive(2'b01, 4); drive(2'b11, 6);
    check("abort_backtrack", int'(count), model);
    drive(2'b00, 4); drive(2'b11, 6);
    check("abort_both_err", int'(count), model);
    drive(2'b01, 4); drive(2'b10, 4); drive(2'b11, 6);
    check("abort_swap_err", int'(count), model);
    // Exit-side backtrack then a real exit still works
    drive(2'b10, 4); drive(2'b00, 4); drive(2'b10, 4); drive(2'b11, 6);
    check("abort_exit_backtrack", int'(count), model);
    exit_seq();

    // Reset mid-sequence discards the passage
    pulse_reset();
    drive(2'b11, 4);
    for (int i = 0; i < 3; i++) entry_seq();
    check("pre_reset_three", int'(count), 3);
    drive(2'b01, 4);
    drive(2'b00, 4);
    pulse_reset();
    drive(2'b00, 2);
    drive(2'b11, 8);
    check("reset_mid_seq", int'(count), 0);

    // Entry still works afterwards
    entry_seq();

    drive(2'b11, 4);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected finish");
    $fatal(1, "timeout");
  end

endmodule
